// File: rtl/systolic_drain.sv
// Output drain for the systolic multiply array: sweeps matrix_index, requantizes each diagonal.
// Latency: start at E0 -> first beat valid from E2, one beat per cycle, done the cycle after last accept.
// Backpressure: out_valid && !out_ready freezes both pipeline stages, matrix_index and the output beat.
//
// Ports: clk/rst_n (async active-low), start + shift_amt (job request), mul_outcome/matrix_index
// (array interface), out_valid/out_ready/out_data/out_addr (result stream), busy/done/sat_flag (status).
module systolic_drain #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 69,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [6:0]                       shift_amt,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  mul_outcome,
    output logic [IDX_WIDTH-1:0]             matrix_index,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]             out_addr,
    output logic                             busy,
    output logic                             done,
    output logic                             sat_flag
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ARRAY_SIZE - 1);
    localparam logic signed [ACC_WIDTH:0] ONE = (ACC_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [6:0]                       shift_q;
    logic [IDX_WIDTH-1:0]             idx_q;
    logic                             a_vld_q;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  a_dat_q;
    logic [IDX_WIDTH-1:0]             a_idx_q;
    logic                             b_vld_q;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_dat_q;
    logic [IDX_WIDTH-1:0]             b_addr_q;
    logic                             b_sat_q;
    logic                             sat_q;

    logic adv;
    logic capture;
    logic last_idx;
    logic start_acc;
    logic hs;

    assign adv       = !b_vld_q || out_ready;
    assign capture   = (state_q == ISSUE) && adv;
    assign last_idx  = (idx_q == LAST_IDX);
    assign start_acc = (state_q == IDLE) && start;
    assign hs        = b_vld_q && out_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            // Leave ISSUE on the same edge that captures the final diagonal.
            ISSUE:   if (capture && last_idx) state_d = FLUSH;
            FLUSH:   if (!a_vld_q && !b_vld_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != IDLE);
        // FLUSH with both stages drained is exactly the cycle after the last handshake.
        done = (state_q == FLUSH) && !a_vld_q && !b_vld_q;
    end

    // ---------------- Requantization of stage A ----------------
    logic signed [ACC_WIDTH:0]        x_ext;
    logic signed [ACC_WIDTH:0]        rnd;
    logic signed [ACC_WIDTH:0]        r;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] rq_dat;
    logic                             rq_sat;

    always_comb begin
        x_ext  = '0;
        rnd    = '0;
        r      = '0;
        rq_dat = '0;
        rq_sat = 1'b0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            // One extra bit of headroom so the rounding add cannot overflow.
            x_ext = signed'({a_dat_q[i*ACC_WIDTH + ACC_WIDTH - 1], a_dat_q[i*ACC_WIDTH +: ACC_WIDTH]});
            rnd   = (shift_q == 7'd0) ? '0 : (ONE <<< (shift_q - 7'd1));
            r     = (x_ext + rnd) >>> shift_q;
            // r fits in DATA_WIDTH iff every bit above the output sign bit matches it.
            if ((&r[ACC_WIDTH:DATA_WIDTH-1]) || !(|r[ACC_WIDTH:DATA_WIDTH-1])) begin
                rq_dat[i*DATA_WIDTH +: DATA_WIDTH] = r[DATA_WIDTH-1:0];
            end else begin
                rq_sat = 1'b1;
                rq_dat[i*DATA_WIDTH +: DATA_WIDTH] = r[ACC_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            idx_q    <= '0;
            a_vld_q  <= 1'b0;
            a_dat_q  <= '0;
            a_idx_q  <= '0;
            b_vld_q  <= 1'b0;
            b_dat_q  <= '0;
            b_addr_q <= '0;
            b_sat_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                shift_q <= shift_amt;
                idx_q   <= '0;
            end else if (capture && !last_idx) begin
                idx_q <= idx_q + IDX_WIDTH'(1);
            end

            // Stage A: fills from the array in ISSUE, otherwise drains into B on adv.
            if (capture) begin
                a_vld_q <= 1'b1;
                a_dat_q <= mul_outcome;
                a_idx_q <= idx_q;
            end else if (adv) begin
                a_vld_q <= 1'b0;
            end

            // Stage B: takes A's requantized lanes, or empties after a handshake.
            if (adv) begin
                b_vld_q <= a_vld_q;
                if (a_vld_q) begin
                    b_dat_q  <= rq_dat;
                    b_addr_q <= a_idx_q;
                    b_sat_q  <= rq_sat;
                end
            end

            // Saturation only counts once the consumer has taken the beat.
            if (start_acc) begin
                sat_q <= 1'b0;
            end else if (hs && b_sat_q) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign matrix_index = idx_q;
    assign out_valid    = b_vld_q;
    assign out_data     = b_dat_q;
    assign out_addr     = b_addr_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain at a reduced 4-lane geometry: scoreboard of expected beats per job.
// Covers latency, rounding, saturation, backpressure, ignored starts and async reset mid-job.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_systolic_drain;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 21;
    localparam int IW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [6:0]        shift_amt = '0;
    logic [N*AW-1:0]   mul_outcome;
    logic [IW-1:0]     matrix_index;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N*DW-1:0]   out_data;
    logic [IW-1:0]     out_addr;
    logic              busy;
    logic              done;
    logic              sat_flag;

    always #5 clk = ~clk;

    systolic_drain #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .shift_amt    (shift_amt),
        .mul_outcome  (mul_outcome),
        .matrix_index (matrix_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag)
    );

    typedef struct packed {
        logic [N*DW-1:0] dat;
        logic [IW-1:0]   addr;
        logic            sat;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    // Model of the array: static accumulators selected by matrix_index.
    logic signed [AW-1:0] tbl [N][N];

    always_comb begin
        mul_outcome = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(matrix_index) == k) begin
                for (int i = 0; i < N; i++) mul_outcome[i*AW +: AW] = tbl[k][i];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rq(input longint x, input int s, output bit st);
        longint r;
        r  = x;
        st = 1'b0;
        if (s > 0) r = r + (longint'(1) << (s - 1));
        r = r >>> s;
        if (r > 127) begin
            r  = 127;
            st = 1'b1;
        end else if (r < -128) begin
            r  = -128;
            st = 1'b1;
        end
        return DW'(r);
    endfunction

    task automatic load_tbl(input int pat);
        int p1 [N] = '{5, 6, -5, -6};
        int p2 [N] = '{200, -200, 127, -128};
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0:       tbl[k][i] = AW'(10 * k + i);
                    1:       tbl[k][i] = AW'(p1[i]);
                    2:       tbl[k][i] = AW'(p2[i]);
                    default: tbl[k][i] = AW'($urandom);
                endcase
            end
        end
    endtask

    task automatic push_exp(input int s, output bit jsat);
        beat_t b;
        bit    st;
        sb.delete();
        jsat = 1'b0;
        for (int k = 0; k < N; k++) begin
            b      = '0;
            b.addr = IW'(k);
            for (int i = 0; i < N; i++) begin
                b.dat[i*DW +: DW] = rq(longint'(tbl[k][i]), s, st);
                b.sat = b.sat | st;
            end
            jsat = jsat | b.sat;
            sb.push_back(b);
        end
    endtask

    // rmode 0: out_ready always 1; rmode 1: out_ready pattern 1,0,0,1,...
    task automatic run_job(input int s, input int rmode, input bit restart_mid, input bit do_reset);
        bit jsat;
        bit seen_done = 1'b0;
        int beats = 0;
        int done_at = -1;
        int n = 0;
        int exp_idx;
        push_exp(s, jsat);
        shift_amt = 7'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        shift_amt = 7'd0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_sat_clr", sat_flag, 0);
        chk("start_idx", matrix_index, 0);
        chk("start_vld", out_valid, 0);
        while (!seen_done && n < 80) begin
            if (n > 0) @(negedge clk);
            out_ready = (rmode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
            start = restart_mid && (n == 3);
            if (do_reset && n == 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_idx", matrix_index, 0);
                chk("rst_vld", out_valid, 0);
                chk("rst_dat", out_data, 0);
                chk("rst_addr", out_addr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sat", sat_flag, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_rel_busy", busy, 0);
                sb.delete();
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                done_at = n;
                if (restart_mid) start = 1'b1;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("beat_dat", out_data, sb[0].dat);
                    chk("beat_addr", out_addr, sb[0].addr);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        beats++;
                    end else begin
                        exp_idx = int'(sb[0].addr) + 2;
                        if (exp_idx > N - 1) exp_idx = N - 1;
                        chk("stall_idx", matrix_index, exp_idx);
                    end
                end
            end
            n++;
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        chk("beats", beats, N);
        chk("sb_empty", sb.size(), 0);
        if (rmode == 0) chk("done_cycle", done_at, N + 2);
        chk("sat_done", sat_flag, jsat);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("sat_hold", sat_flag, jsat);
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) tbl[k][i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_idx", matrix_index, 0);
        chk("reset_vld", out_valid, 0);
        chk("reset_dat", out_data, 0);
        chk("reset_addr", out_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sat", sat_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_tbl(0); run_job(0, 0, 1'b0, 1'b0);   // pass-through ramp
        load_tbl(1); run_job(2, 0, 1'b0, 1'b0);   // round-half-up, arithmetic shift
        load_tbl(2); run_job(0, 0, 1'b0, 1'b0);   // saturation both directions
        load_tbl(0); run_job(0, 1, 1'b0, 1'b0);   // backpressure; sat cleared by start
        load_tbl(0); run_job(0, 0, 1'b1, 1'b0);   // start mid-job and on done ignored
        load_tbl(2); run_job(0, 0, 1'b0, 1'b1);   // async reset mid-job
        load_tbl(0); run_job(0, 0, 1'b0, 1'b0);   // full job after reset
        repeat (4) begin
            load_tbl(3);
            run_job(int'($urandom_range(0, AW - 1)), 1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
